cnf_loader: RTL and testbench
=============================

# cnf_loader

Front-end stage of the SAT solver that accepts a CNF problem as a stream of bin-partitioned clauses, writes them into the global clause memory, and records per-bin base address and clause count in the bin table. Once the stream is complete it starts the solver top, waits for it to finish, and holds the global SAT/UNSAT result for the host until acknowledged. It sits directly upstream of the solver top: it fills the memories it reads and drives its start/done handshake.

## Interface
- NUM_VARS_A_BIN, 8, variables per bin; clause word is 2 bits per variable
- WIDTH_CLAUSES, NUM_VARS_A_BIN*2, clause word width
- WIDTH_VARS, 12, width of global variable count
- WIDTH_BIN_ID, 10, width of bin index
- ADDR_WIDTH_CLAUSES, 9, clause memory address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- load_start_i  in  1  pulse in IDLE: begin a new problem
- nv_all_i  in  WIDTH_VARS  total variables, sampled with load_start_i
- in_valid_i  in  1  clause word valid
- in_ready_o  out  1  loader accepts a clause word
- in_data_i  in  WIDTH_CLAUSES  clause; per variable 00 absent, 01 positive, 10 negative, 11 illegal
- in_bin_last_i  in  1  word is the last clause of the current bin
- in_last_i  in  1  word is the last clause of the problem (implies bin last)
- mem_we_o  out  1  clause memory write strobe
- mem_addr_o  out  ADDR_WIDTH_CLAUSES  clause memory write address
- mem_wdata_o  out  WIDTH_CLAUSES  clause memory write data
- bin_we_o  out  1  bin table write strobe
- bin_id_o  out  WIDTH_BIN_ID  bin table index
- bin_base_o  out  ADDR_WIDTH_CLAUSES  first clause address of the bin
- bin_nc_o  out  ADDR_WIDTH_CLAUSES+1  clauses in the bin
- nv_all_o  out  WIDTH_VARS  registered variable count to solver
- nb_all_o  out  WIDTH_BIN_ID+1  number of bins loaded
- start_o  out  1  one-cycle start pulse to solver
- done_i  in  1  solver done pulse
- global_sat_i, global_unsat_i  in  1 each  solver result, valid with done_i
- result_valid_o  out  1  result held for host
- result_sat_o, result_unsat_o  out  1 each  captured result
- err_o  out  1  sticky load error (illegal literal or memory overflow)
- result_ack_i  in  1  host acknowledge; frees loader

## Operation
- States: IDLE, LOAD, BIN_WR, START, WAIT, REPORT.
- IDLE: load_start_i -> clear address/bin/clause counters and err_o, latch nv_all_o, go LOAD.
- LOAD: in_ready_o=1. Each handshake writes word at current address, address+1, bin clause count+1. Any 2-bit field ==11 sets err_o; word is still written. in_bin_last_i -> BIN_WR.
- BIN_WR: in_ready_o=0; bin_we_o with bin_id, bin_base, count; bin_id+1, base <- next address, count <- 0. Then in_last (latched) -> START else LOAD.
- Overflow: handshake when address already wrapped (2^ADDR_WIDTH_CLAUSES words stored) sets err_o and suppresses mem_we_o; bin count saturates no further.
- START: if err_o, skip solver, go REPORT with sat=0, unsat=0; else pulse start_o, go WAIT.
- WAIT: done_i -> capture global_sat_i/global_unsat_i, go REPORT.
- REPORT: result_valid_o=1 until result_ack_i, then IDLE. load_start_i ignored outside IDLE.
- nb_all_o = number of BIN_WR writes, saturating at 2^WIDTH_BIN_ID; exceeding bin capacity sets err_o.

## Timing
- All outputs registered; reset values all 0 (state IDLE).
- mem_we_o/addr/wdata appear one cycle after the accepting handshake.
- bin_we_o asserted exactly one cycle, the cycle after the bin-last handshake; one bubble per bin on in_ready_o.
- start_o one cycle after leaving the last BIN_WR; result_valid_o the cycle after done_i.
- done_i outside WAIT ignored. Reset mid-load aborts instantly; no partial bin table entry written.

## Structure
- Shared package: state enum, 2-bit literal encoding constants (LIT_NONE, LIT_POS, LIT_NEG, LIT_BAD), widths derived from parameters.
- One sub-module natural: cnf_lit_check (combinational per-word illegal-literal detector).

## Test plan
- 2 bins of 3 and 2 clauses, nv=16 -> 5 mem writes at 0..4; bin table (0,0,3),(1,3,2); nb_all_o=2; one start_o pulse.
- Solver done_i with sat=1 -> result_valid_o=1, result_sat_o=1 held until result_ack_i, then IDLE.
- Clause with field 11 -> err_o=1, no start_o, REPORT with sat=unsat=0.
- ADDR_WIDTH_CLAUSES=3, 9 clauses one bin -> 8 writes, 9th suppressed, err_o=1.
- in_valid_i held high across bin boundary -> in_ready_o low exactly one cycle, no word lost.
- rst low mid-LOAD -> all outputs 0 same cycle; fresh load then succeeds from address 0.

Source files
------------

// File: rtl/cnf_loader_pkg.sv
// Shared types and constants for the CNF loader front end.
// Holds the FSM state enum, 2-bit literal encodings and default widths.
package cnf_loader_pkg;

    localparam int NUM_VARS_A_BIN_DEF     = 8;
    localparam int WIDTH_CLAUSES_DEF      = NUM_VARS_A_BIN_DEF * 2;
    localparam int WIDTH_VARS_DEF         = 12;
    localparam int WIDTH_BIN_ID_DEF       = 10;
    localparam int ADDR_WIDTH_CLAUSES_DEF = 9;

    localparam logic [1:0] LIT_NONE = 2'b00;
    localparam logic [1:0] LIT_POS  = 2'b01;
    localparam logic [1:0] LIT_NEG  = 2'b10;
    localparam logic [1:0] LIT_BAD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BIN_WR,
        S_START,
        S_WAIT,
        S_REPORT
    } state_e;

endpackage

// File: rtl/cnf_lit_check.sv
// Combinational illegal-literal detector for one clause word.
// Ports: data_i clause word in, bad_o high if any 2-bit field is 11.
module cnf_lit_check
    import cnf_loader_pkg::*;
#(
    parameter int NUM_VARS = NUM_VARS_A_BIN_DEF
) (
    input  logic [2*NUM_VARS-1:0] data_i,
    output logic                  bad_o
);

    always_comb begin
        bad_o = 1'b0;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (data_i[2*i +: 2] == LIT_BAD) begin
                bad_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnf_loader.sv
// CNF loader: streams bin-partitioned clauses into clause memory, writes the
// bin table, starts the solver and holds its SAT/UNSAT result for the host.
// Ports: load_start/nv_all (problem start), in_* (clause stream, valid/ready),
// mem_* (clause memory write), bin_* (bin table write), nv_all_o/nb_all_o,
// start_o/done_i/global_* (solver handshake), result_* (host), err_o.
module cnf_loader
    import cnf_loader_pkg::*;
#(
    parameter int NUM_VARS_A_BIN     = NUM_VARS_A_BIN_DEF,
    parameter int WIDTH_CLAUSES      = NUM_VARS_A_BIN * 2,
    parameter int WIDTH_VARS         = WIDTH_VARS_DEF,
    parameter int WIDTH_BIN_ID       = WIDTH_BIN_ID_DEF,
    parameter int ADDR_WIDTH_CLAUSES = ADDR_WIDTH_CLAUSES_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_start_i,
    input  logic [WIDTH_VARS-1:0]         nv_all_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [WIDTH_CLAUSES-1:0]      in_data_i,
    input  logic                          in_bin_last_i,
    input  logic                          in_last_i,
    output logic                          mem_we_o,
    output logic [ADDR_WIDTH_CLAUSES-1:0] mem_addr_o,
    output logic [WIDTH_CLAUSES-1:0]      mem_wdata_o,
    output logic                          bin_we_o,
    output logic [WIDTH_BIN_ID-1:0]       bin_id_o,
    output logic [ADDR_WIDTH_CLAUSES-1:0] bin_base_o,
    output logic [ADDR_WIDTH_CLAUSES:0]   bin_nc_o,
    output logic [WIDTH_VARS-1:0]         nv_all_o,
    output logic [WIDTH_BIN_ID:0]         nb_all_o,
    output logic                          start_o,
    input  logic                          done_i,
    input  logic                          global_sat_i,
    input  logic                          global_unsat_i,
    output logic                          result_valid_o,
    output logic                          result_sat_o,
    output logic                          result_unsat_o,
    output logic                          err_o,
    input  logic                          result_ack_i
);

    localparam int AW = ADDR_WIDTH_CLAUSES;
    localparam int BW = WIDTH_BIN_ID;

    state_e                   state_q, state_d;
    // addr_q[AW] set means the whole memory has been filled
    logic [AW:0]              addr_q, addr_d;
    logic [AW-1:0]            base_q, base_d;
    logic [AW:0]              nc_q, nc_d;
    logic [BW-1:0]            bid_q, bid_d;
    logic [BW:0]              nb_q, nb_d;
    logic                     last_q, last_d;
    logic                     err_q, err_d;
    logic                     rdy_q, rdy_d;
    logic                     mwe_q, mwe_d;
    logic [AW-1:0]            maddr_q, maddr_d;
    logic [WIDTH_CLAUSES-1:0] mdata_q, mdata_d;
    logic                     bwe_q, bwe_d;
    logic [BW-1:0]            bid_o_q, bid_o_d;
    logic [AW-1:0]            bbase_q, bbase_d;
    logic [AW:0]              bnc_q, bnc_d;
    logic [WIDTH_VARS-1:0]    nv_q, nv_d;
    logic                     start_q, start_d;
    logic                     rv_q, rv_d;
    logic                     rsat_q, rsat_d;
    logic                     runsat_q, runsat_d;
    logic                     lit_bad;

    cnf_lit_check #(
        .NUM_VARS (WIDTH_CLAUSES / 2)
    ) u_lit_check (
        .data_i (in_data_i),
        .bad_o  (lit_bad)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        base_d   = base_q;
        nc_d     = nc_q;
        bid_d    = bid_q;
        nb_d     = nb_q;
        last_d   = last_q;
        err_d    = err_q;
        rdy_d    = rdy_q;
        mwe_d    = 1'b0;
        maddr_d  = maddr_q;
        mdata_d  = mdata_q;
        bwe_d    = 1'b0;
        bid_o_d  = bid_o_q;
        bbase_d  = bbase_q;
        bnc_d    = bnc_q;
        nv_d     = nv_q;
        start_d  = 1'b0;
        rv_d     = rv_q;
        rsat_d   = rsat_q;
        runsat_d = runsat_q;

        unique case (state_q)
            S_IDLE: begin
                if (load_start_i) begin
                    addr_d  = '0;
                    base_d  = '0;
                    nc_d    = '0;
                    bid_d   = '0;
                    nb_d    = '0;
                    last_d  = 1'b0;
                    err_d   = 1'b0;
                    nv_d    = nv_all_i;
                    rdy_d   = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid_i) begin
                    if (lit_bad) begin
                        err_d = 1'b1;
                    end
                    if (addr_q[AW]) begin
                        err_d = 1'b1;
                    end else begin
                        mwe_d   = 1'b1;
                        maddr_d = addr_q[AW-1:0];
                        mdata_d = in_data_i;
                        addr_d  = addr_q + 1'b1;
                        nc_d    = nc_q + 1'b1;
                    end
                    // The bin entry is issued on the same edge as the last
                    // word so bin_we_o lands in the BIN_WR bubble cycle.
                    if (in_bin_last_i || in_last_i) begin
                        rdy_d   = 1'b0;
                        last_d  = in_last_i;
                        state_d = S_BIN_WR;
                        if (nb_q[BW]) begin
                            err_d = 1'b1;
                        end else begin
                            bwe_d   = 1'b1;
                            bid_o_d = bid_q;
                            bbase_d = base_q;
                            bnc_d   = nc_d;
                            bid_d   = bid_q + 1'b1;
                            nb_d    = nb_q + 1'b1;
                        end
                        base_d = addr_d[AW-1:0];
                        nc_d   = '0;
                    end
                end
            end
            S_BIN_WR: begin
                if (last_q) begin
                    state_d = S_START;
                end else begin
                    rdy_d   = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_START: begin
                if (err_q) begin
                    rv_d     = 1'b1;
                    rsat_d   = 1'b0;
                    runsat_d = 1'b0;
                    state_d  = S_REPORT;
                end else begin
                    start_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_i) begin
                    rv_d     = 1'b1;
                    rsat_d   = global_sat_i;
                    runsat_d = global_unsat_i;
                    state_d  = S_REPORT;
                end
            end
            S_REPORT: begin
                if (result_ack_i) begin
                    rv_d     = 1'b0;
                    rsat_d   = 1'b0;
                    runsat_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            base_q   <= '0;
            nc_q     <= '0;
            bid_q    <= '0;
            nb_q     <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            rdy_q    <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mdata_q  <= '0;
            bwe_q    <= 1'b0;
            bid_o_q  <= '0;
            bbase_q  <= '0;
            bnc_q    <= '0;
            nv_q     <= '0;
            start_q  <= 1'b0;
            rv_q     <= 1'b0;
            rsat_q   <= 1'b0;
            runsat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            base_q   <= base_d;
            nc_q     <= nc_d;
            bid_q    <= bid_d;
            nb_q     <= nb_d;
            last_q   <= last_d;
            err_q    <= err_d;
            rdy_q    <= rdy_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mdata_q  <= mdata_d;
            bwe_q    <= bwe_d;
            bid_o_q  <= bid_o_d;
            bbase_q  <= bbase_d;
            bnc_q    <= bnc_d;
            nv_q     <= nv_d;
            start_q  <= start_d;
            rv_q     <= rv_d;
            rsat_q   <= rsat_d;
            runsat_q <= runsat_d;
        end
    end

    assign in_ready_o     = rdy_q;
    assign mem_we_o       = mwe_q;
    assign mem_addr_o     = maddr_q;
    assign mem_wdata_o    = mdata_q;
    assign bin_we_o       = bwe_q;
    assign bin_id_o       = bid_o_q;
    assign bin_base_o     = bbase_q;
    assign bin_nc_o       = bnc_q;
    assign nv_all_o       = nv_q;
    assign nb_all_o       = nb_q;
    assign start_o        = start_q;
    assign result_valid_o = rv_q;
    assign result_sat_o   = rsat_q;
    assign result_unsat_o = runsat_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_cnf_loader.sv
// Directed self-checking bench for cnf_loader.
// Drives a default-width instance and a 3-bit-address instance side by side.
module tb_cnf_loader;

    localparam int WC  = 16;
    localparam int WV  = 12;
    localparam int WB  = 10;
    localparam int AW  = 9;
    localparam int SAW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          load_start = 0;
    logic [WV-1:0] nv_all     = '0;
    logic          in_valid   = 0;
    logic [WC-1:0] in_data    = '0;
    logic          in_bin_last = 0;
    logic          in_last    = 0;
    logic          done       = 0;
    logic          gsat       = 0;
    logic          gunsat     = 0;
    logic          ack        = 0;

    logic          in_ready, mem_we, bin_we, start, rv, rsat, runsat, err;
    logic [AW-1:0] mem_addr, bin_base;
    logic [WC-1:0] mem_wdata;
    logic [WB-1:0] bin_id;
    logic [AW:0]   bin_nc;
    logic [WV-1:0] nv_o;
    logic [WB:0]   nb_o;

    logic           s_ready, s_mem_we, s_bin_we, s_start, s_rv, s_rsat;
    logic           s_runsat, s_err;
    logic [SAW-1:0] s_mem_addr, s_bin_base;
    logic [WC-1:0]  s_mem_wdata;
    logic [WB-1:0]  s_bin_id;
    logic [SAW:0]   s_bin_nc;
    logic [WV-1:0]  s_nv_o;
    logic [WB:0]    s_nb_o;

    cnf_loader u_dut (
        .clk(clk), .rst(rst), .load_start_i(load_start), .nv_all_i(nv_all),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .in_bin_last_i(in_bin_last), .in_last_i(in_last),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .bin_we_o(bin_we), .bin_id_o(bin_id), .bin_base_o(bin_base),
        .bin_nc_o(bin_nc), .nv_all_o(nv_o), .nb_all_o(nb_o),
        .start_o(start), .done_i(done), .global_sat_i(gsat),
        .global_unsat_i(gunsat), .result_valid_o(rv), .result_sat_o(rsat),
        .result_unsat_o(runsat), .err_o(err), .result_ack_i(ack)
    );

    cnf_loader #(.ADDR_WIDTH_CLAUSES(SAW)) u_small (
        .clk(clk), .rst(rst), .load_start_i(load_start), .nv_all_i(nv_all),
        .in_valid_i(in_valid), .in_ready_o(s_ready), .in_data_i(in_data),
        .in_bin_last_i(in_bin_last), .in_last_i(in_last),
        .mem_we_o(s_mem_we), .mem_addr_o(s_mem_addr),
        .mem_wdata_o(s_mem_wdata), .bin_we_o(s_bin_we), .bin_id_o(s_bin_id),
        .bin_base_o(s_bin_base), .bin_nc_o(s_bin_nc), .nv_all_o(s_nv_o),
        .nb_all_o(s_nb_o), .start_o(s_start), .done_i(done),
        .global_sat_i(gsat), .global_unsat_i(gunsat),
        .result_valid_o(s_rv), .result_sat_o(s_rsat),
        .result_unsat_o(s_runsat), .err_o(s_err), .result_ack_i(ack)
    );

    int pass_n = 0;
    int tot_n  = 0;

    // Output logs, sampled on the falling edge
    int            mem_n, bin_n, start_n;
    logic [AW-1:0] m_addr [32];
    logic [WC-1:0] m_data [32];
    logic [WB-1:0] b_id   [8];
    logic [AW-1:0] b_base [8];
    logic [AW:0]   b_nc   [8];
    int            s_mem_n, s_bin_n, s_start_n;
    logic [SAW-1:0] s_last_addr;
    logic [SAW:0]   s_last_nc;

    always @(negedge clk) begin
        if (mem_we) begin
            if (mem_n < 32) begin
                m_addr[mem_n] = mem_addr;
                m_data[mem_n] = mem_wdata;
            end
            mem_n++;
        end
        if (bin_we) begin
            if (bin_n < 8) begin
                b_id[bin_n]   = bin_id;
                b_base[bin_n] = bin_base;
                b_nc[bin_n]   = bin_nc;
            end
            bin_n++;
        end
        if (start) start_n++;
        if (s_mem_we) begin
            s_last_addr = s_mem_addr;
            s_mem_n++;
        end
        if (s_bin_we) begin
            s_last_nc = s_bin_nc;
            s_bin_n++;
        end
        if (s_start) s_start_n++;
    end

    task automatic clr_logs();
        mem_n = 0; bin_n = 0; start_n = 0;
        s_mem_n = 0; s_bin_n = 0; s_start_n = 0;
        s_last_addr = '0; s_last_nc = '0;
    endtask

    task automatic idle_in();
        in_valid = 0; in_bin_last = 0; in_last = 0; in_data = '0;
    endtask

    task automatic do_reset();
        rst = 0;
        idle_in();
        load_start = 0; done = 0; ack = 0; gsat = 0; gunsat = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        clr_logs();
    endtask

    task automatic start_load(input logic [WV-1:0] nv);
        load_start = 1;
        nv_all = nv;
        @(posedge clk);
        #1 load_start = 0;
    endtask

    // Holds in_valid until accepted; returns cycles spent with ready low.
    task automatic send_word(input logic [WC-1:0] d, input logic bl,
                             input logic l, input bit sel,
                             output int waits);
        bit got = 0;
        in_valid = 1; in_data = d; in_bin_last = bl; in_last = l;
        waits = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((sel ? s_ready : in_ready) === 1'b1) begin
                got = 1;
                break;
            end
            waits++;
        end
        @(posedge clk);
        #1;
        tot_n++;
        if (!got) $display("FAIL send_timeout: ready never seen, word %h", d);
        else pass_n++;
    endtask

    task automatic wait_rv(input bit sel);
        bit got = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if ((sel ? s_rv : rv) === 1'b1) begin
                got = 1;
                break;
            end
        end
        tot_n++;
        if (!got) $display("FAIL wait_result: result_valid got 0 expected 1");
        else pass_n++;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_in();
        #3;
        tot_n++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, bin_we, bin_id, bin_base,
             bin_nc, nv_o, nb_o, start, rv, rsat, runsat, err} !== '0)
            $display("FAIL reset_outputs: some output nonzero, expected 0");
        else pass_n++;
        do_reset();
    endtask

    task automatic test_two_bins();
        int w;
        logic [WC-1:0] d [5];
        d[0] = 16'h0001; d[1] = 16'h0106; d[2] = 16'h2A00;
        d[3] = 16'h5555; d[4] = 16'h4812;
        do_reset();
        start_load(12'd16);
        send_word(d[0], 0, 0, 0, w);
        send_word(d[1], 0, 0, 0, w);
        send_word(d[2], 1, 0, 0, w);
        send_word(d[3], 0, 0, 0, w);
        send_word(d[4], 1, 1, 0, w);
        idle_in();
        repeat (8) @(posedge clk);
        #1;
        tot_n++;
        if (mem_n !== 5) $display("FAIL two_mem_n: got %0d expected 5", mem_n);
        else pass_n++;
        for (int i = 0; i < 5; i++) begin
            tot_n++;
            if (m_addr[i] !== AW'(i) || m_data[i] !== d[i])
                $display("FAIL two_mem_%0d: got %0d/%h expected %0d/%h",
                         i, m_addr[i], m_data[i], i, d[i]);
            else pass_n++;
        end
        tot_n++;
        if (bin_n !== 2) $display("FAIL two_bin_n: got %0d expected 2", bin_n);
        else pass_n++;
        tot_n++;
        if (b_id[0] !== 0 || b_base[0] !== 0 || b_nc[0] !== 3)
            $display("FAIL bin0: got %0d,%0d,%0d expected 0,0,3",
                     b_id[0], b_base[0], b_nc[0]);
        else pass_n++;
        tot_n++;
        if (b_id[1] !== 1 || b_base[1] !== 3 || b_nc[1] !== 2)
            $display("FAIL bin1: got %0d,%0d,%0d expected 1,3,2",
                     b_id[1], b_base[1], b_nc[1]);
        else pass_n++;
        tot_n++;
        if (nb_o !== 2 || nv_o !== 16)
            $display("FAIL nb_nv: got %0d,%0d expected 2,16", nb_o, nv_o);
        else pass_n++;
        tot_n++;
        if (start_n !== 1 || err !== 0)
            $display("FAIL two_start: got %0d err %0b expected 1 err 0",
                     start_n, err);
        else pass_n++;
    endtask

    task automatic test_result();
        @(negedge clk);
        tot_n++;
        if (rv !== 0) $display("FAIL rv_early: got %0b expected 0", rv);
        else pass_n++;
        @(posedge clk);
        #1 done = 1; gsat = 1;
        @(posedge clk);
        #1 done = 0; gsat = 0;
        @(negedge clk);
        tot_n++;
        if ({rv, rsat, runsat} !== 3'b110)
            $display("FAIL result_sat: got %b expected 110", {rv, rsat, runsat});
        else pass_n++;
        @(posedge clk);
        #1 load_start = 1;
        @(posedge clk);
        #1 load_start = 0;
        repeat (3) @(negedge clk);
        tot_n++;
        if ({rv, rsat, in_ready} !== 3'b110)
            $display("FAIL result_hold: got %b expected 110",
                     {rv, rsat, in_ready});
        else pass_n++;
        @(posedge clk);
        #1 ack = 1;
        @(posedge clk);
        #1 ack = 0;
        @(negedge clk);
        tot_n++;
        if ({rv, rsat} !== 2'b00)
            $display("FAIL result_ack: got %b expected 00", {rv, rsat});
        else pass_n++;
        @(posedge clk);
        #1 done = 1; gsat = 1;
        @(posedge clk);
        #1 done = 0; gsat = 0;
        repeat (2) @(negedge clk);
        tot_n++;
        if (rv !== 0 || start_n !== 1)
            $display("FAIL done_in_idle: got rv %0b starts %0d expected 0,1",
                     rv, start_n);
        else pass_n++;
    endtask

    task automatic test_illegal();
        int w;
        do_reset();
        start_load(12'd8);
        send_word(16'h0300, 1, 1, 0, w);
        idle_in();
        wait_rv(0);
        tot_n++;
        if ({err, rsat, runsat} !== 3'b100 || start_n !== 0)
            $display("FAIL illegal: got err/sat/unsat %b starts %0d expected 100,0",
                     {err, rsat, runsat}, start_n);
        else pass_n++;
        tot_n++;
        if (mem_n !== 1 || m_data[0] !== 16'h0300)
            $display("FAIL illegal_write: got %0d/%h expected 1/0300",
                     mem_n, m_data[0]);
        else pass_n++;
        @(posedge clk);
        #1 ack = 1;
        @(posedge clk);
        #1 ack = 0;
    endtask

    task automatic test_overflow();
        int w;
        do_reset();
        start_load(12'd8);
        for (int i = 0; i < 9; i++)
            send_word(16'h0001, (i == 8), (i == 8), 1, w);
        idle_in();
        wait_rv(1);
        tot_n++;
        if (s_mem_n !== 8 || s_last_addr !== 3'd7)
            $display("FAIL ovf_writes: got %0d last %0d expected 8 last 7",
                     s_mem_n, s_last_addr);
        else pass_n++;
        tot_n++;
        if (s_bin_n !== 1 || s_last_nc !== 4'd8)
            $display("FAIL ovf_bin: got %0d nc %0d expected 1 nc 8",
                     s_bin_n, s_last_nc);
        else pass_n++;
        tot_n++;
        if ({s_err, s_rsat, s_runsat} !== 3'b100 || s_start_n !== 0)
            $display("FAIL ovf_err: got %b starts %0d expected 100,0",
                     {s_err, s_rsat, s_runsat}, s_start_n);
        else pass_n++;
        tot_n++;
        if (mem_n !== 9 || err !== 0)
            $display("FAIL ovf_wide: got %0d err %0b expected 9 err 0",
                     mem_n, err);
        else pass_n++;
    endtask

    task automatic test_back_to_back();
        int w;
        int stall = 0;
        logic [WC-1:0] d [5];
        d[0] = 16'h1000; d[1] = 16'h0200; d[2] = 16'h0040;
        d[3] = 16'h0008; d[4] = 16'h9000;
        do_reset();
        start_load(12'd4);
        send_word(d[0], 0, 0, 0, w);
        send_word(d[1], 1, 0, 0, w);
        for (int i = 2; i < 5; i++) begin
            send_word(d[i], (i == 4), (i == 4), 0, w);
            stall += w;
        end
        idle_in();
        repeat (6) @(posedge clk);
        #1;
        tot_n++;
        if (stall !== 1) $display("FAIL b2b_bubble: got %0d expected 1", stall);
        else pass_n++;
        tot_n++;
        if (mem_n !== 5 || m_addr[2] !== 2 || m_data[2] !== d[2] ||
            m_data[4] !== d[4])
            $display("FAIL b2b_words: got n %0d data2 %h expected 5, %h",
                     mem_n, m_data[2], d[2]);
        else pass_n++;
        tot_n++;
        if (b_nc[0] !== 2 || b_base[1] !== 2 || b_nc[1] !== 3)
            $display("FAIL b2b_bins: got %0d,%0d,%0d expected 2,2,3",
                     b_nc[0], b_base[1], b_nc[1]);
        else pass_n++;
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        start_load(12'd8);
        send_word(16'h0001, 0, 0, 0, w);
        send_word(16'h0002, 0, 0, 0, w);
        #3 rst = 0;
        #1;
        tot_n++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, bin_we, bin_id, bin_base,
             bin_nc, nv_o, nb_o, start, rv, rsat, runsat, err} !== '0)
            $display("FAIL mid_reset: outputs nonzero, expected 0");
        else pass_n++;
        tot_n++;
        if (bin_n !== 0) $display("FAIL mid_bin: got %0d expected 0", bin_n);
        else pass_n++;
        idle_in();
        @(posedge clk);
        #1 rst = 1;
        clr_logs();
        start_load(12'd8);
        send_word(16'h0004, 0, 0, 0, w);
        send_word(16'h0010, 1, 1, 0, w);
        idle_in();
        repeat (6) @(posedge clk);
        #1;
        tot_n++;
        if (mem_n !== 2 || m_addr[0] !== 0 || m_addr[1] !== 1)
            $display("FAIL mid_fresh_mem: got %0d,%0d,%0d expected 2,0,1",
                     mem_n, m_addr[0], m_addr[1]);
        else pass_n++;
        tot_n++;
        if (bin_n !== 1 || b_base[0] !== 0 || b_nc[0] !== 2 || start_n !== 1)
            $display("FAIL mid_fresh_bin: got %0d,%0d,%0d,%0d expected 1,0,2,1",
                     bin_n, b_base[0], b_nc[0], start_n);
        else pass_n++;
    endtask

    initial begin
        clr_logs();
        test_reset();
        test_two_bins();
        test_result();
        test_illegal();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

endmodule
